// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit and its scoreboard.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_EX  = 2'b10
   } fwd_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Long-latency scoreboard: tracks in-flight destination registers with a
// per-entry countdown and reports RAW/WAW matches against the ID stage.
module hazard_scoreboard #(
   parameter int NUM_SRC  = 2,
   parameter int REG_AW   = 5,
   parameter int SB_DEPTH = 4,
   parameter int LAT_W    = 5,
   localparam int CNT_W   = $clog2(SB_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_regwrite,
   input  logic                      alloc,
   input  logic [REG_AW-1:0]         alloc_rd,
   input  logic [LAT_W-1:0]          alloc_lat,
   output logic [NUM_SRC-1:0]        raw_hit,
   output logic                      waw_hit,
   output logic                      full,
   output logic [CNT_W-1:0]          count
);

   logic [SB_DEPTH-1:0]             valid_q, valid_d;
   logic [SB_DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
   logic [SB_DEPTH-1:0][LAT_W-1:0]  cnt_q, cnt_d;
   logic                            found;
   logic [CNT_W-1:0]                count_v;

   // Allocation only looks at registered valid bits, so a slot retiring on
   // this edge is not reused until the next one.
   always_comb begin
      valid_d = valid_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      found   = 1'b0;
      for (int e = 0; e < SB_DEPTH; e++) begin
         if (valid_q[e]) begin
            cnt_d[e] = cnt_q[e] - LAT_W'(1);
            if (cnt_q[e] == LAT_W'(1)) valid_d[e] = 1'b0;
         end else if (alloc && !found) begin
            found      = 1'b1;
            valid_d[e] = 1'b1;
            rd_d[e]    = alloc_rd;
            cnt_d[e]   = (alloc_lat == '0) ? LAT_W'(1) : alloc_lat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   // Contents read as empty while reset is held.
   always_comb begin
      raw_hit = '0;
      waw_hit = 1'b0;
      count_v = '0;
      for (int e = 0; e < SB_DEPTH; e++) begin
         if (valid_q[e]) begin
            count_v = count_v + CNT_W'(1);
            for (int i = 0; i < NUM_SRC; i++) begin
               if (id_rs[i*REG_AW +: REG_AW] != '0 && id_rs[i*REG_AW +: REG_AW] == rd_q[e])
                  raw_hit[i] = 1'b1;
            end
            if (id_regwrite && id_rd != '0 && id_rd == rd_q[e]) waw_hit = 1'b1;
         end
      end
      if (rst) begin
         raw_hit = '0;
         waw_hit = 1'b0;
         count_v = '0;
      end
   end

   assign count = count_v;
   assign full  = (count_v == CNT_W'(SB_DEPTH));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use and long-latency
// scoreboard stalls, plus a saturating stall-cycle counter.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int REG_AW   = 5,
   parameter int SB_DEPTH = 4,
   parameter int LAT_W    = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_SRC*REG_AW-1:0]         id_rs,
   input  logic [REG_AW-1:0]                 id_rd,
   input  logic                              id_regwrite,
   input  logic [NUM_SRC*REG_AW-1:0]         ex_rs,
   input  logic [REG_AW-1:0]                 ex_rd,
   input  logic                              ex_regwrite,
   input  logic                              ex_memread,
   input  logic [REG_AW-1:0]                 mem_rd,
   input  logic                              mem_regwrite,
   input  logic [REG_AW-1:0]                 wb_rd,
   input  logic                              wb_regwrite,
   input  logic                              mc_issue,
   input  logic [REG_AW-1:0]                 mc_rd,
   input  logic [LAT_W-1:0]                  mc_lat,
   output logic [NUM_SRC*2-1:0]              fwd_sel,
   output logic                              stall,
   output logic                              bubble_ex,
   output logic                              sb_full,
   output logic [$clog2(SB_DEPTH+1)-1:0]     sb_count,
   output logic [31:0]                       stall_cnt
);

   logic [NUM_SRC-1:0] raw_hit;
   logic               waw_hit;
   logic               load_use;
   logic               alloc;
   logic [31:0]        stall_cnt_q, stall_cnt_d;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      logic [REG_AW-1:0] rs;
      fwd_e              sel;
      assign rs = ex_rs[i*REG_AW +: REG_AW];
      always_comb begin
         sel = FWD_REG;
         if (mem_regwrite && mem_rd != '0 && mem_rd == rs)   sel = FWD_EX;
         else if (wb_regwrite && wb_rd != '0 && wb_rd == rs) sel = FWD_MEM;
      end
      assign fwd_sel[i*2 +: 2] = sel;
   end

   always_comb begin
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ex_memread && ex_regwrite && ex_rd != '0 && ex_rd == id_rs[i*REG_AW +: REG_AW])
            load_use = 1'b1;
      end
   end

   assign stall     = load_use | (|raw_hit) | waw_hit | (mc_issue & sb_full);
   assign bubble_ex = stall;
   assign alloc     = mc_issue & ~stall & (mc_rd != '0);

   hazard_scoreboard #(
      .NUM_SRC  (NUM_SRC),
      .REG_AW   (REG_AW),
      .SB_DEPTH (SB_DEPTH),
      .LAT_W    (LAT_W)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .alloc       (alloc),
      .alloc_rd    (mc_rd),
      .alloc_lat   (mc_lat),
      .raw_hit     (raw_hit),
      .waw_hit     (waw_hit),
      .full        (sb_full),
      .count       (sb_count)
   );

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: vector table, directed multi-cycle sequences and
// randomized traffic checked against a queue-based reference model.
module tb_hazard_unit;
   import hazard_pkg::*;

   localparam int NUM_SRC = 2, REG_AW = 5, SB_DEPTH = 4, LAT_W = 5;
   localparam int CW = $clog2(SB_DEPTH + 1);

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_SRC*REG_AW-1:0] id_rs, ex_rs;
   logic [REG_AW-1:0]         id_rd, ex_rd, mem_rd, wb_rd, mc_rd;
   logic                      id_regwrite, ex_regwrite, ex_memread;
   logic                      mem_regwrite, wb_regwrite, mc_issue;
   logic [LAT_W-1:0]          mc_lat;
   logic [NUM_SRC*2-1:0]      fwd_sel;
   logic                      stall, bubble_ex, sb_full;
   logic [CW-1:0]             sb_count;
   logic [31:0]               stall_cnt;

   int checks = 0, failures = 0;

   hazard_unit #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .SB_DEPTH(SB_DEPTH), .LAT_W(LAT_W)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .fwd_sel(fwd_sel), .stall(stall),
      .bubble_ex(bubble_ex), .sb_full(sb_full), .sb_count(sb_count), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: in-flight long-latency ops as (rd, cycles remaining).
   int     q_rd[$];
   int     q_rem[$];
   longint m_scnt = 0;
   logic   obs_stall, obs_full;
   logic [CW-1:0] obs_cnt;
   logic [31:0]   obs_scnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_check_and_step();
      logic [1:0] efwd;
      logic lu, raw, waw, st, full;
      int   cnt, e, d;
      cnt = rst ? 0 : q_rd.size();
      full = (cnt == SB_DEPTH);
      lu = 0; raw = 0; waw = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         e = int'(ex_rs[i*REG_AW +: REG_AW]);
         d = int'(id_rs[i*REG_AW +: REG_AW]);
         if (mem_regwrite && mem_rd != 0 && int'(mem_rd) == e)  efwd = FWD_EX;
         else if (wb_regwrite && wb_rd != 0 && int'(wb_rd) == e) efwd = FWD_MEM;
         else efwd = FWD_REG;
         chk($sformatf("fwd_sel[%0d]", i), 64'(fwd_sel[i*2 +: 2]), 64'(efwd));
         if (ex_memread && ex_regwrite && ex_rd != 0 && int'(ex_rd) == d) lu = 1;
         if (!rst && d != 0) foreach (q_rd[k]) if (q_rd[k] == d) raw = 1;
      end
      if (!rst && id_regwrite && id_rd != 0) foreach (q_rd[k]) if (q_rd[k] == int'(id_rd)) waw = 1;
      st = lu | raw | waw | (mc_issue & full);
      chk("stall", 64'(stall), 64'(st));
      chk("bubble_ex", 64'(bubble_ex), 64'(st));
      chk("sb_count", 64'(sb_count), 64'(cnt));
      chk("sb_full", 64'(sb_full), 64'(full));
      chk("stall_cnt", 64'(stall_cnt), rst ? 64'd0 : 64'(m_scnt));
      if (rst) begin
         q_rd.delete(); q_rem.delete(); m_scnt = 0;
      end else begin
         if (st && m_scnt < 64'hFFFF_FFFF) m_scnt++;
         for (int k = q_rd.size() - 1; k >= 0; k--) begin
            q_rem[k]--;
            if (q_rem[k] == 0) begin q_rd.delete(k); q_rem.delete(k); end
         end
         if (mc_issue && !st && mc_rd != 0) begin
            q_rd.push_back(int'(mc_rd));
            q_rem.push_back(mc_lat == 0 ? 1 : int'(mc_lat));
         end
      end
   endtask

   task automatic cyc();
      #1;
      model_check_and_step();
      obs_stall = stall; obs_full = sb_full; obs_cnt = sb_count; obs_scnt = stall_cnt;
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; id_rs = '0; ex_rs = '0; id_rd = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
      mc_rd = '0; id_regwrite = 0; ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0;
      wb_regwrite = 0; mc_issue = 0; mc_lat = '0;
   endtask

   task automatic do_reset();
      idle(); rst = 1; cyc(); rst = 0;
   endtask

   typedef struct {
      logic [9:0] id_rs, ex_rs;
      logic [4:0] ex_rd;
      logic       ex_mr, ex_rw;
      logic [4:0] mem_rd;
      logic       mem_rw;
      logic [4:0] wb_rd;
      logic       wb_rw;
      logic [3:0] fwd;
      logic       st;
   } vec_t;

   vec_t tbl[9];
   logic [5:0] pat;
   int n;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{{5'd0,5'd0}, {5'd5,5'd5}, 5'd0, 0, 0, 5'd5, 1, 5'd5, 1, 4'b1010, 0};
      tbl[1] = '{{5'd0,5'd0}, {5'd5,5'd5}, 5'd0, 0, 0, 5'd6, 1, 5'd5, 1, 4'b0101, 0};
      tbl[2] = '{{5'd0,5'd0}, {5'd5,5'd5}, 5'd0, 0, 0, 5'd0, 1, 5'd5, 1, 4'b0101, 0};
      tbl[3] = '{{5'd0,5'd0}, {5'd3,5'd5}, 5'd0, 0, 0, 5'd3, 1, 5'd5, 1, 4'b1001, 0};
      tbl[4] = '{{5'd0,5'd0}, {5'd5,5'd5}, 5'd0, 0, 0, 5'd5, 0, 5'd5, 0, 4'b0000, 0};
      tbl[5] = '{{5'd7,5'd0}, {5'd0,5'd0}, 5'd7, 1, 1, 5'd0, 0, 5'd0, 0, 4'b0000, 1};
      tbl[6] = '{{5'd0,5'd0}, {5'd0,5'd0}, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0, 4'b0000, 0};
      tbl[7] = '{{5'd7,5'd0}, {5'd0,5'd0}, 5'd7, 0, 1, 5'd0, 0, 5'd0, 0, 4'b0000, 0};
      tbl[8] = '{{5'd7,5'd0}, {5'd0,5'd0}, 5'd7, 1, 0, 5'd0, 0, 5'd0, 0, 4'b0000, 0};

      do_reset();
      chk("reset sb_count", 64'(obs_cnt), 64'd0);
      chk("reset stall_cnt", 64'(obs_scnt), 64'd0);

      foreach (tbl[v]) begin
         idle();
         id_rs = tbl[v].id_rs; ex_rs = tbl[v].ex_rs; ex_rd = tbl[v].ex_rd;
         ex_memread = tbl[v].ex_mr; ex_regwrite = tbl[v].ex_rw;
         mem_rd = tbl[v].mem_rd; mem_regwrite = tbl[v].mem_rw;
         wb_rd = tbl[v].wb_rd; wb_regwrite = tbl[v].wb_rw;
         #1;
         chk($sformatf("vec%0d fwd_sel", v), 64'(fwd_sel), 64'(tbl[v].fwd));
         chk($sformatf("vec%0d stall", v), 64'(stall), 64'(tbl[v].st));
         #0 cyc_from_mid();
      end

      // Long-latency RAW: rd 9, latency 4.
      do_reset();
      mc_issue = 1; mc_rd = 5'd9; mc_lat = 5'd4; cyc();
      idle(); id_rs = {5'd0, 5'd9};
      for (int c = 0; c < 6; c++) begin
         cyc(); pat[c] = obs_stall;
         if (c == 4) chk("raw stall_cnt", 64'(obs_scnt), 64'd4);
      end
      chk("raw stall pattern", 64'(pat), 64'b001111);

      // mc_rd==0 allocates nothing; mc_lat==0 behaves as 1.
      do_reset();
      mc_issue = 1; mc_rd = 5'd0; mc_lat = 5'd5; cyc();
      idle(); cyc();
      chk("rd0 no alloc", 64'(obs_cnt), 64'd0);
      mc_issue = 1; mc_rd = 5'd4; mc_lat = 5'd0; cyc();
      idle(); id_rs = {5'd4, 5'd0}; cyc();
      chk("lat0 stall", 64'(obs_stall), 64'd1);
      cyc();
      chk("lat0 released", 64'(obs_stall), 64'd0);

      // Structural: fill, then a fifth issue waits for the first retire.
      do_reset();
      for (int r = 1; r <= 4; r++) begin
         mc_issue = 1; mc_rd = REG_AW'(r); mc_lat = 5'd10; cyc();
      end
      mc_rd = 5'd5; mc_lat = 5'd3;
      #1;
      chk("full after 4", 64'(sb_full), 64'd1);
      chk("count after 4", 64'(sb_count), 64'd4);
      n = 0;
      for (int c = 0; c < 20; c++) begin
         cyc();
         if (!obs_stall) break;
         n++;
      end
      chk("struct stall cycles", 64'(n), 64'd7);
      chk("struct count at alloc", 64'(obs_cnt), 64'd3);
      chk("struct stall_cnt", 64'(obs_scnt), 64'd7);
      idle(); id_rs = {5'd0, 5'd5}; cyc();
      chk("fifth allocated", 64'(obs_stall), 64'd1);
      chk("count after fifth", 64'(obs_cnt), 64'd3);

      // WAW then mid-run reset.
      do_reset();
      mc_issue = 1; mc_rd = 5'd3; mc_lat = 5'd6; cyc();
      idle(); cyc();
      id_rd = 5'd3; id_regwrite = 1; cyc();
      chk("waw stall", 64'(obs_stall), 64'd1);
      rst = 1; cyc();
      chk("rst stall", 64'(obs_stall), 64'd0);
      chk("rst count", 64'(obs_cnt), 64'd0);
      rst = 0; cyc();
      chk("post-rst stall", 64'(obs_stall), 64'd0);
      chk("post-rst count", 64'(obs_cnt), 64'd0);
      chk("post-rst stall_cnt", 64'(obs_scnt), 64'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) < 2);
         for (int i = 0; i < NUM_SRC; i++) begin
            id_rs[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            ex_rs[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
         end
         id_rd = REG_AW'($urandom_range(0, 7)); id_regwrite = 1'($urandom);
         ex_rd = REG_AW'($urandom_range(0, 7)); ex_regwrite = 1'($urandom);
         ex_memread = ($urandom_range(0, 3) == 0);
         mem_rd = REG_AW'($urandom_range(0, 7)); mem_regwrite = 1'($urandom);
         wb_rd = REG_AW'($urandom_range(0, 7)); wb_regwrite = 1'($urandom);
         mc_issue = ($urandom_range(0, 3) == 0);
         mc_rd = REG_AW'($urandom_range(0, 7)); mc_lat = LAT_W'($urandom_range(0, 12));
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Table vectors already waited #1 into the cycle; finish it through the model.
   task automatic cyc_from_mid();
      model_check_and_step();
      obs_stall = stall; obs_full = sb_full; obs_cnt = sb_count; obs_scnt = stall_cnt;
      @(negedge clk);
   endtask

endmodule
